// File: rtl/ddr2_v11_0_if_csr_b2p_pkg.sv
// Shared constants, byte classes and classification helper for the CSR byte-to-packet decoder.
package ddr2_v11_0_if_csr_b2p_pkg;

    localparam logic [7:0] B2P_SOP_CHAR = 8'h7A;
    localparam logic [7:0] B2P_EOP_CHAR = 8'h7B;
    localparam logic [7:0] B2P_CHN_CHAR = 8'h7C;
    localparam logic [7:0] B2P_ESC_CHAR = 8'h7D;
    localparam logic [7:0] B2P_ESC_XOR  = 8'h20;

    typedef enum logic [2:0] {
        CLS_DATA,
        CLS_SOP,
        CLS_EOP,
        CLS_CHN,
        CLS_ESC
    } byte_class_e;

    // Classify a raw (unescaped) byte against the configured marker set.
    function automatic byte_class_e classify(
        input logic [7:0] b,
        input logic [7:0] sop_c,
        input logic [7:0] eop_c,
        input logic [7:0] chn_c,
        input logic [7:0] esc_c
    );
        if (b == sop_c) return CLS_SOP;
        if (b == eop_c) return CLS_EOP;
        if (b == chn_c) return CLS_CHN;
        if (b == esc_c) return CLS_ESC;
        return CLS_DATA;
    endfunction

endpackage

// File: rtl/ddr2_v11_0_if_csr_b2p_out_reg.sv
// Single-entry output holding register with full-throughput ready/valid handshake.
module ddr2_v11_0_if_csr_b2p_out_reg #(
    parameter int unsigned CHANNEL_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load,
    input  logic [7:0]               load_data,
    input  logic                     load_sop,
    input  logic                     load_eop,
    input  logic [CHANNEL_WIDTH-1:0] load_channel,
    input  logic                     out_ready,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [7:0]               out_data,
    output logic                     out_startofpacket,
    output logic                     out_endofpacket,
    output logic [CHANNEL_WIDTH-1:0] out_channel
);

    // Space exists when empty or when the held beat leaves on this edge.
    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid         <= 1'b0;
            out_data          <= 8'h00;
            out_startofpacket <= 1'b0;
            out_endofpacket   <= 1'b0;
            out_channel       <= '0;
        end else if (load) begin
            out_valid         <= 1'b1;
            out_data          <= load_data;
            out_startofpacket <= load_sop;
            out_endofpacket   <= load_eop;
            out_channel       <= load_channel;
        end else if (out_ready) begin
            out_valid         <= 1'b0;
        end
    end

endmodule

// File: rtl/ddr2_v11_0_if_csr_bytes_to_packets.sv
// Decodes the escaped CSR byte stream into an Avalon-ST packet stream with SOP/EOP/channel.
// Optional DDR2_V11_0_B2P_PROTOCOL_ERR_EN adds a one-cycle protocol_error pulse output.
module ddr2_v11_0_if_csr_bytes_to_packets
    import ddr2_v11_0_if_csr_b2p_pkg::*;
#(
    parameter int unsigned CHANNEL_WIDTH = 8,
    parameter logic [7:0]  SOP_CHAR      = B2P_SOP_CHAR,
    parameter logic [7:0]  EOP_CHAR      = B2P_EOP_CHAR,
    parameter logic [7:0]  CHN_CHAR      = B2P_CHN_CHAR,
    parameter logic [7:0]  ESC_CHAR      = B2P_ESC_CHAR
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     in_ready,
    input  logic                     in_valid,
    input  logic [7:0]               in_data,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [7:0]               out_data,
    output logic                     out_startofpacket,
    output logic                     out_endofpacket,
    output logic [CHANNEL_WIDTH-1:0] out_channel
`ifdef DDR2_V11_0_B2P_PROTOCOL_ERR_EN
    ,
    output logic                     protocol_error
`endif
);

    logic                     sop_pend, eop_pend, chn_pend, esc_pend;
    logic [CHANNEL_WIDTH-1:0] cur_channel;
    logic                     sop_pend_nxt, eop_pend_nxt, chn_pend_nxt, esc_pend_nxt;
    logic [CHANNEL_WIDTH-1:0] cur_channel_nxt;
    logic                     accept;
    logic                     emit;
    logic [7:0]               value;
    byte_class_e              raw_cls;
    byte_class_e              cls;

    // Decoder state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            sop_pend    <= 1'b0;
            eop_pend    <= 1'b0;
            chn_pend    <= 1'b0;
            esc_pend    <= 1'b0;
            cur_channel <= '0;
        end else begin
            sop_pend    <= sop_pend_nxt;
            eop_pend    <= eop_pend_nxt;
            chn_pend    <= chn_pend_nxt;
            esc_pend    <= esc_pend_nxt;
            cur_channel <= cur_channel_nxt;
        end
    end

    // Byte classification and next-state; an escaped byte is always ordinary data.
    always_comb begin
        accept          = in_valid && in_ready;
        raw_cls         = classify(in_data, SOP_CHAR, EOP_CHAR, CHN_CHAR, ESC_CHAR);
        cls             = esc_pend ? CLS_DATA : raw_cls;
        value           = esc_pend ? (in_data ^ B2P_ESC_XOR) : in_data;
        sop_pend_nxt    = sop_pend;
        eop_pend_nxt    = eop_pend;
        chn_pend_nxt    = chn_pend;
        esc_pend_nxt    = esc_pend;
        cur_channel_nxt = cur_channel;
        emit            = 1'b0;
        if (accept) begin
            case (cls)
                CLS_ESC: esc_pend_nxt = 1'b1;
                CLS_SOP: sop_pend_nxt = 1'b1;
                CLS_EOP: eop_pend_nxt = 1'b1;
                CLS_CHN: chn_pend_nxt = 1'b1;
                default: begin
                    esc_pend_nxt = 1'b0;
                    if (chn_pend) begin
                        chn_pend_nxt    = 1'b0;
                        cur_channel_nxt = CHANNEL_WIDTH'(value);
                    end else begin
                        emit         = 1'b1;
                        sop_pend_nxt = 1'b0;
                        eop_pend_nxt = 1'b0;
                    end
                end
            endcase
        end
    end

    ddr2_v11_0_if_csr_b2p_out_reg #(
        .CHANNEL_WIDTH(CHANNEL_WIDTH)
    ) u_out_reg (
        .clk              (clk),
        .reset            (reset),
        .load             (emit),
        .load_data        (value),
        .load_sop         (sop_pend),
        .load_eop         (eop_pend),
        .load_channel     (cur_channel),
        .out_ready        (out_ready),
        .in_ready         (in_ready),
        .out_valid        (out_valid),
        .out_data         (out_data),
        .out_startofpacket(out_startofpacket),
        .out_endofpacket  (out_endofpacket),
        .out_channel      (out_channel)
    );

`ifdef DDR2_V11_0_B2P_PROTOCOL_ERR_EN
    logic perr_nxt;

    // Flags a marker following ESC, or SOP arriving while an EOP is still pending.
    always_comb begin
        perr_nxt = 1'b0;
        if (accept) begin
            if (esc_pend)
                perr_nxt = (raw_cls != CLS_DATA);
            else
                perr_nxt = (raw_cls == CLS_SOP) && eop_pend;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) protocol_error <= 1'b0;
        else       protocol_error <= perr_nxt;
    end
`endif

endmodule

// File: doc/ddr2_v11_0_if_csr_bytes_to_packets.md
Name: ddr2_v11_0_if_csr_bytes_to_packets

Overview:
- Decodes the escaped byte stream arriving from the JTAG/CSR byte transport into an Avalon-ST packet stream with SOP, EOP and channel.
- Inverse end of the transmit-side packets-to-bytes path; feeds the CSR master's packet interface.
- Control bytes are consumed silently.
- Output is a registered single-entry holding stage with full-throughput handshake.

Parameters:
- CHANNEL_WIDTH, 8, width of out_channel; decoded channel bytes are truncated to this width.
- SOP_CHAR, 8'h7A, start-of-packet marker.
- EOP_CHAR, 8'h7B, end-of-packet marker.
- CHN_CHAR, 8'h7C, channel marker.
- ESC_CHAR, 8'h7D, escape marker.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_ready  out  1  byte accepted when in_valid && in_ready
- in_valid  in  1  input byte valid
- in_data  in  8  escaped input byte
- out_ready  in  1  downstream ready
- out_valid  out  1  output beat valid
- out_data  out  8  decoded data byte
- out_startofpacket  out  1  first beat of packet
- out_endofpacket  out  1  last beat of packet
- out_channel  out  CHANNEL_WIDTH  channel of current beat

Behaviour:
- Reset values:
  - out_valid=0, out_data=0, out_startofpacket=0, out_endofpacket=0, out_channel=0.
  - Internal flags sop_pend, eop_pend, chn_pend, esc_pend=0; cur_channel=0.
- Reset asserted mid-operation discards the held beat and all pending flags on that edge.
- in_ready = !out_valid || out_ready. Combinational; no dependency on in_valid.
- An accepted byte b is classified as follows:
  - esc_pend=1: value = b ^ 8'h20, treated as an ordinary (non-special) byte; esc_pend clears.
  - b==ESC_CHAR: set esc_pend; no output.
  - b==SOP_CHAR: set sop_pend; no output.
  - b==EOP_CHAR: set eop_pend; no output.
  - b==CHN_CHAR: set chn_pend; no output.
  - Otherwise: value = b.
- Handling of an ordinary value:
  - If chn_pend: cur_channel <= value[CHANNEL_WIDTH-1:0]; chn_pend clears; no output.
  - Else emit a beat next cycle: out_data=value, out_startofpacket=sop_pend, out_endofpacket=eop_pend, out_channel=cur_channel.
  - Clear sop_pend and eop_pend on emission.
- Latency: data byte accepted at edge N gives out_valid=1 after edge N; one beat per cycle sustained with out_ready=1.
- A held beat stays stable while out_valid && !out_ready. out_valid drops after a transfer unless a new data byte is accepted on the same edge.
- Marker sequencing:
  - SOP and EOP both pending on one data byte gives a one-beat packet with out_startofpacket=out_endofpacket=1.
  - Repeated markers are idempotent.
  - A channel marker mid-packet changes the channel for following beats only.
  - A channel byte never clears sop_pend or eop_pend.
- Boundaries:
  - Escaped channel value: 7C 7D 5A gives channel 0x7A.
  - in_valid without in_ready: the byte is not consumed and no state changes.

Optional Feature:
- Macro: DDR2_V11_0_B2P_PROTOCOL_ERR_EN.
- Enabled: adds output protocol_error (1 bit), a registered pulse for exactly one cycle after accepting either of:
  - a special char (7A–7D) while esc_pend=1;
  - SOP_CHAR while eop_pend=1.
- Enabled, decode is unchanged: escaped specials are XORed as normal; the SOP still sets sop_pend. Reset value is 0.
- Disabled: no port and no logic.

Decomposition:
- Package ddr2_v11_0_if_csr_b2p_pkg holds:
  - the marker constants 8'h7A/7B/7C/7D;
  - ESC_XOR 8'h20;
  - the enum of byte classes (DATA, SOP, EOP, CHN, ESC).
- One natural sub-module: ddr2_v11_0_if_csr_b2p_out_reg, the single-entry output holding register with the in_ready equation.

Test Plan:
- Bytes 7A 11 22 7B 33, out_ready=1 -> beats 11 (sop=1), 22, 33 (eop=1), all channel 0, each one cycle after its acceptance.
- Bytes 7C 05 7A 7B 44 -> one beat data 44, sop=1, eop=1, channel 5.
- Bytes 7A 7D 5A 7D 5D 7B 7D 5C -> beats 7A (sop), 7D, 7C (eop).
- Beat 55 pending with out_ready=0 for 4 cycles -> in_ready=0, output stable; out_ready=1 -> transfer, next byte accepted the same cycle.
- Reset pulsed after 7A 7C -> following bytes 66 7B 77 give beat 66 (sop=0, channel 0) then 77 (eop=1).
- Macro enabled, bytes 7D 7A -> protocol_error high exactly one cycle; beat data 5A follows the next data byte path correctly.
